// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - iterative shift-add multiplier (MUL/MLA) with early exit and pipeline stall
module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic             accumulate,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc_in,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             n_flag,
    output logic             z_flag
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mcand, mplier, prod, result_q;
    logic [WIDTH-1:0] prod_nxt, mplier_nxt;
    logic [CW-1:0]    cnt;
    logic             finish, load;

    always_comb begin
        prod_nxt   = prod + (mplier[0] ? mcand : '0);
        mplier_nxt = mplier >> 1;
        // Leave as soon as no set multiplier bits remain, bounded by WIDTH iterations.
        finish     = (mplier_nxt == '0) || (cnt == CW'(WIDTH - 1));
        load       = start && !cancel && (state != RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (cancel) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = RUN;
                RUN:     if (finish) state_nxt = DONE;
                DONE:    state_nxt = start ? RUN : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy  = (state == RUN);
        done  = (state == DONE);
        stall = busy | (start & (state != RUN));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand    <= '0;
            mplier   <= '0;
            prod     <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else if (load) begin
            mcand  <= a;
            mplier <= b;
            prod   <= accumulate ? acc_in : '0;
            cnt    <= '0;
        end else if (state == RUN && !cancel) begin
            mcand  <= mcand << 1;
            mplier <= mplier_nxt;
            prod   <= prod_nxt;
            cnt    <= cnt + CW'(1);
            if (finish) begin
                result_q <= prod_nxt;
            end
        end
    end

    assign result = result_q;
    assign n_flag = result_q[WIDTH-1];
    assign z_flag = (result_q == '0);

endmodule

// File: tb/tb_mul_iter.sv
// tb/tb_mul_iter.sv - randomized self-checking bench for mul_iter against an arithmetic model
module tb_mul_iter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic        accumulate = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] acc_in = '0;
    logic        busy, stall, done, n_flag, z_flag;
    logic [31:0] result;

    int vectors = 0;
    int miscompares = 0;

    mul_iter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .cancel(cancel),
        .accumulate(accumulate), .a(a), .b(b), .acc_in(acc_in),
        .busy(busy), .stall(stall), .done(done), .result(result),
        .n_flag(n_flag), .z_flag(z_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_res(input logic [31:0] x, input logic [31:0] y,
                                              input logic [31:0] acc, input logic accm);
        logic [63:0] p;
        p = {32'd0, x} * {32'd0, y} + (accm ? {32'd0, acc} : 64'd0);
        return p[31:0];
    endfunction

    function automatic int model_k(input logic [31:0] y);
        for (int i = 31; i >= 0; i--) begin
            if (y[i]) return i + 1;
        end
        return 1;
    endfunction

    // Issues one operation from IDLE and measures what the DUT did; called at posedge+1.
    task automatic drive_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] acc,
                            input logic accm, output int nbusy, output logic stall_ok,
                            output logic done_ok, output logic [31:0] res,
                            output logic n, output logic z);
        start = 1'b1; a = x; b = y; acc_in = acc; accumulate = accm;
        #1;
        stall_ok = stall;
        @(posedge clk); #1;
        start = 1'b0;
        nbusy = 0;
        while (busy && nbusy < 100) begin
            stall_ok = stall_ok & stall;
            nbusy++;
            @(posedge clk); #1;
        end
        done_ok = done;
        res = result; n = n_flag; z = z_flag;
        @(posedge clk); #1;
        done_ok = done_ok & !done;
    endtask

    task automatic test_reset();
        int seen;
        if ({busy, done, result, n_flag, z_flag} !== {2'b00, 32'd0, 2'b01}) begin
            miscompares++; $display("FAIL reset_init: got %h required %h", {busy, done, result, n_flag, z_flag}, {2'b00, 32'd0, 2'b01});
        end
        vectors++;
        #3 reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; a = 32'd3; b = 32'hFFFF_FFFF; accumulate = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        if ({busy, done, result, z_flag} !== {2'b00, 32'd0, 1'b1}) begin
            miscompares++; $display("FAIL reset_mid_run: got %h required %h", {busy, done, result, z_flag}, {2'b00, 32'd0, 1'b1});
        end
        vectors++;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        seen = 0;
        repeat (40) begin
            if (done || busy) seen++;
            @(posedge clk); #1;
        end
        if (seen !== 0 || result !== 32'd0) begin
            miscompares++; $display("FAIL reset_no_done: active cycles %0d result %h required 0 and 0", seen, result);
        end
        vectors++;
    endtask

    task automatic test_mul_basic();
        int nb; logic st, dn, n, z; logic [31:0] r;
        drive_op(32'd7, 32'd6, 32'd0, 1'b0, nb, st, dn, r, n, z);
        if (nb !== 3 || st !== 1'b1 || dn !== 1'b1) begin
            miscompares++; $display("FAIL mul_basic_timing: busy %0d stall %b done %b required 3 1 1", nb, st, dn);
        end
        vectors++;
        if ({r, n, z} !== {32'd42, 2'b00}) begin
            miscompares++; $display("FAIL mul_basic_result: got %h n%b z%b required 0000002a n0 z0", r, n, z);
        end
        vectors++;
    endtask

    task automatic test_mla_wrap();
        int nb; logic st, dn, n, z; logic [31:0] r;
        drive_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b1, nb, st, dn, r, n, z);
        if (nb !== 32 || dn !== 1'b1 || r !== 32'd2 || n !== 1'b0) begin
            miscompares++; $display("FAIL mla_wrap: busy %0d done %b result %h n %b required 32 1 00000002 0", nb, dn, r, n);
        end
        vectors++;
    endtask

    task automatic test_zero_mplier();
        int nb; logic st, dn, n, z; logic [31:0] r;
        drive_op(32'h1234, 32'd0, 32'd5, 1'b1, nb, st, dn, r, n, z);
        if (nb !== 1 || dn !== 1'b1 || r !== 32'd5 || z !== 1'b0) begin
            miscompares++; $display("FAIL zero_mla: busy %0d done %b result %h z %b required 1 1 00000005 0", nb, dn, r, z);
        end
        vectors++;
        drive_op(32'h1234, 32'd0, 32'd5, 1'b0, nb, st, dn, r, n, z);
        if (nb !== 1 || dn !== 1'b1 || r !== 32'd0 || z !== 1'b1) begin
            miscompares++; $display("FAIL zero_mul: busy %0d done %b result %h z %b required 1 1 00000000 1", nb, dn, r, z);
        end
        vectors++;
    endtask

    task automatic test_back_to_back();
        int nb;
        start = 1'b1; a = 32'd2; b = 32'd3; accumulate = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        nb = 0;
        while (busy && nb < 100) begin nb++; @(posedge clk); #1; end
        if (done !== 1'b1 || result !== 32'd6 || nb !== 2) begin
            miscompares++; $display("FAIL b2b_first: done %b result %h busy %0d required 1 00000006 2", done, result, nb);
        end
        vectors++;
        start = 1'b1; a = 32'h8000_0000; b = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL b2b_no_idle: busy %b required 1", busy);
        end
        vectors++;
        nb = 0;
        while (busy && nb < 100) begin nb++; @(posedge clk); #1; end
        if (done !== 1'b1 || result !== 32'h8000_0000 || n_flag !== 1'b1 || nb !== 1) begin
            miscompares++; $display("FAIL b2b_second: done %b result %h n %b busy %0d required 1 80000000 1 1", done, result, n_flag, nb);
        end
        vectors++;
        @(posedge clk); #1;
    endtask

    task automatic test_cancel();
        int nb; logic st, dn, n, z; logic [31:0] r; int seen;
        drive_op(32'd7, 32'd6, 32'd0, 1'b0, nb, st, dn, r, n, z);
        start = 1'b1; a = 32'd5; b = 32'h100; accumulate = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd42) begin
            miscompares++; $display("FAIL cancel_run: busy %b done %b result %h required 0 0 0000002a", busy, done, result);
        end
        vectors++;
        seen = 0;
        repeat (15) begin if (done || busy) seen++; @(posedge clk); #1; end
        if (seen !== 0) begin
            miscompares++; $display("FAIL cancel_no_done: active cycles %0d required 0", seen);
        end
        vectors++;
        start = 1'b1; cancel = 1'b1; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd42) begin
            miscompares++; $display("FAIL cancel_start_idle: busy %b done %b result %h required 0 0 0000002a", busy, done, result);
        end
        vectors++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int nb; logic st, dn, n, z; logic [31:0] r, x, y, acc, exp; logic accm;
        for (int i = 0; i < 40; i++) begin
            x = $urandom; acc = $urandom; accm = 1'($urandom_range(0, 1));
            y = $urandom >> $urandom_range(0, 31);
            exp = model_res(x, y, acc, accm);
            drive_op(x, y, acc, accm, nb, st, dn, r, n, z);
            if (r !== exp || n !== exp[31] || z !== (exp == 32'd0)) begin
                miscompares++; $display("FAIL rand_result[%0d]: got %h n%b z%b required %h", i, r, n, z, exp);
            end
            vectors++;
            if (nb !== model_k(y) || st !== 1'b1 || dn !== 1'b1) begin
                miscompares++; $display("FAIL rand_timing[%0d]: busy %0d stall %b done %b required %0d 1 1", i, nb, st, dn, model_k(y));
            end
            vectors++;
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_mul_basic();
        test_mla_wrap();
        test_zero_mplier();
        test_back_to_back();
        test_cancel();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_iter.md
Name: mul_iter

Overview:
Iterative shift-add multiplier for MUL/MLA in the execute stage of the pipelined ARM core. Operands come from the register-file read ports (rd1/rd2, plus a third read for the accumulator). The result goes to the writeback mux alongside the ALU result. While the block is busy it asserts a stall toward the hazard logic, and it exits early once the remaining multiplier bits are zero.

Parameters:
WIDTH, 32, operand and result width in bits (low WIDTH bits of the product only).

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous active-low reset; state cleared immediately while low
start  input  1  request a new multiply; sampled at rising edge
cancel  input  1  pipeline flush; abort the in-flight operation
accumulate  input  1  1 = MLA (add acc_in), 0 = MUL; sampled with start
a  input  WIDTH  multiplicand (Rm)
b  input  WIDTH  multiplier (Rs)
acc_in  input  WIDTH  accumulator (Rn); used only when accumulate=1
busy  output  1  operation in progress
stall  output  1  pipeline stall request
done  output  1  one-cycle pulse; result and flags valid
result  output  WIDTH  (a*b + (accumulate ? acc_in : 0)) mod 2^WIDTH
n_flag  output  1  result[WIDTH-1]
z_flag  output  1  result == 0

Behaviour:
- States: IDLE, RUN, DONE.
- Registers: mcand (WIDTH), mplier (WIDTH), prod (WIDTH), cnt (clog2(WIDTH) bits), result (WIDTH).
- Reset (reset=0, asynchronous):
  - state=IDLE; busy=0, done=0, result=0, n_flag=0, z_flag=1.
  - All internal registers are cleared.
  - Reset asserted mid-operation discards the operation, with no done pulse.
- IDLE, start=1:
  - Capture mcand=a, mplier=b, cnt=0, prod = accumulate ? acc_in : 0.
  - Go to RUN. start=0 stays in IDLE.
- RUN, each cycle:
  - If mplier[0], prod += mcand, truncated to WIDTH (no carry-out kept).
  - mcand <<= 1; mplier >>= 1; cnt++.
  - If next mplier == 0 or cnt == WIDTH-1: latch result = next prod and go to DONE.
- RUN cycle count k = max(1, index of highest set bit of b + 1). For b=0, k=1 with no add. For b=2^WIDTH-1, k=WIDTH.
- DONE:
  - done=1 for exactly one cycle.
  - If start=1 in this cycle, capture the new operands and go to RUN (back-to-back); otherwise go to IDLE.
- result, n_flag and z_flag hold their value until the next completion or reset. n_flag and z_flag are combinational from the result register.
- busy = (state == RUN). stall = busy | (start & state != RUN), which holds the decode/execute registers from the start cycle onward.
- start while in RUN is ignored; the upstream stall prevents it.
- cancel=1 in any state: go to IDLE next edge, no done, result unchanged.
  - cancel takes priority over start in the same cycle.
  - cancel in the DONE cycle still leaves that cycle's done=1 visible (it is already registered).
- Latency: start sampled at edge E0 → done high during the cycle after edge E0+k, i.e. k+1 cycles after the start edge.
- Signedness is irrelevant for the low WIDTH bits; no signed/unsigned distinction.

Test Plan:
- Reset: reset low mid-RUN (a=3, b=0xFFFF_FFFF) → busy=0 immediately; no done after release; result=0, z_flag=1.
- MUL basic: a=7, b=6, accumulate=0, start one cycle → busy for 3 cycles, done pulse on cycle 4; result=42, n=0, z=0; stall high from the start cycle through the last RUN cycle.
- MLA wrap: a=0xFFFF_FFFF, b=0xFFFF_FFFF, acc_in=1, accumulate=1 → 32 RUN cycles; result=0x0000_0002, n=0.
- Zero multiplier: a=0x1234, b=0, acc_in=5, accumulate=1 → 1 RUN cycle; result=5. Repeat with accumulate=0 → result=0, z=1.
- Back-to-back: start asserted in the DONE cycle of a=2,b=3 with new a=0x8000_0000, b=1 → first result 6, then after 1 RUN cycle result=0x8000_0000, n=1. No idle cycle in between.
- Cancel: start a=5, b=0x100; cancel in the 3rd RUN cycle → IDLE next edge, no done; result keeps its previous value. Assert cancel and start together in IDLE → remains IDLE.
